// File: rtl/mem_pkg.sv
// Shared types and constants for the system RAM arbiter slice.
package mem_pkg;
   localparam int MEM_ADDR_W = 9;

   localparam logic M_FETCH = 1'b0;
   localparam logic M_DATA  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: combinational winner plus pointer update for the owner's register.
// Zero latency; no backpressure, the caller gates updates with en.
module rr_arb2
   import mem_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   input  logic en,
   output logic gnt_vld,
   output logic gnt_id,
   output logic ptr_upd,
   output logic ptr_nxt
);

   // On contention the pointer decides; otherwise the lone requester wins.
   assign gnt_vld = req0 | req1;
   assign gnt_id  = (req0 && req1) ? ptr : (req1 ? M_DATA : M_FETCH);
   assign ptr_upd = en & gnt_vld;
   assign ptr_nxt = ~gnt_id;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter and one-shot access sequencer for the 512-word system RAM.
// Latency: ack 2 cycles after req sample (1 for out-of-range); occupancy 3 (2) cycles.
// Backpressure: a master holds req until its ack; the loser waits until the FSM is back in IDLE.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = MEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [31:0]       m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [31:0]       m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [31:0]       ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_read,
   output logic              ram_write,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy,
   output logic              grant
);

   state_t state;
   logic   ptr;
   logic   lat_we;

   logic   gnt_vld;
   logic   gnt_id;
   logic   ptr_upd;
   logic   ptr_nxt;

   logic              sel_we;
   logic [31:0]       sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_oor;

   rr_arb2 u_rr_arb2 (
      .req0    (m0_req),
      .req1    (m1_req),
      .ptr     (ptr),
      .en      (state == IDLE),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id),
      .ptr_upd (ptr_upd),
      .ptr_nxt (ptr_nxt)
   );

   assign sel_we    = (gnt_id == M_DATA) ? m1_we    : m0_we;
   assign sel_addr  = (gnt_id == M_DATA) ? m1_addr  : m0_addr;
   assign sel_wdata = (gnt_id == M_DATA) ? m1_wdata : m0_wdata;
   assign sel_oor   = |sel_addr[31:ADDR_W];

   assign busy = (state != IDLE);

   // Strobes, ack and err are all registers so nothing combinational reaches them from req.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= M_FETCH;
         grant     <= M_FETCH;
         lat_we    <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
         ram_read  <= 1'b0;
         ram_write <= 1'b0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_err    <= 1'b0;
         m1_err    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ptr_upd) begin
                  ptr <= ptr_nxt;
               end
               if (gnt_vld) begin
                  grant  <= gnt_id;
                  lat_we <= sel_we;
                  if (sel_oor) begin
                     // Rejected without touching the RAM; ram_addr/ram_din keep their old value.
                     state <= DONE;
                     if (gnt_id == M_DATA) begin
                        m1_ack   <= 1'b1;
                        m1_err   <= 1'b1;
                        m1_rdata <= '0;
                     end else begin
                        m0_ack   <= 1'b1;
                        m0_err   <= 1'b1;
                        m0_rdata <= '0;
                     end
                  end else begin
                     state     <= ACCESS;
                     ram_addr  <= {{(32-ADDR_W){1'b0}}, sel_addr[ADDR_W-1:0]};
                     ram_din   <= sel_wdata;
                     ram_read  <= ~sel_we;
                     ram_write <= sel_we;
                  end
               end
            end
            ACCESS: begin
               ram_read  <= 1'b0;
               ram_write <= 1'b0;
               state     <= DONE;
               if (grant == M_DATA) begin
                  m1_ack <= 1'b1;
                  if (!lat_we) begin
                     m1_rdata <= ram_dout;
                  end
               end else begin
                  m0_ack <= 1'b1;
                  if (!lat_we) begin
                     m0_rdata <= ram_dout;
                  end
               end
            end
            DONE: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               m0_err <= 1'b0;
               m1_err <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
